// File: rtl/upg_pkg.sv
// Shared definitions for the UART program loader: loader states, segment
// header bit positions, status bytes and the per-segment word limit.
package upg_pkg;

    typedef enum logic [2:0] {
        HDR_SEG,
        HDR_LO,
        HDR_HI,
        DATA,
        DONE,
        ERR
    } ld_state_t;

    localparam int          SEG_TARGET_BIT = 0;
    localparam int          SEG_LAST_BIT   = 7;
    localparam logic [7:0]  ACK_OK         = 8'h4F;
    localparam logic [7:0]  ACK_ERR        = 8'h45;
    localparam int          MAX_WORDS      = 16384;

    // A segment byte is well formed only when its reserved bits 6:1 are clear.
    function automatic logic seg_ok(input logic [7:0] b);
        return (b[6:1] == 6'd0);
    endfunction

endpackage

// File: rtl/uart_byte_rx.sv
// Oversampled 8N1 UART receiver. The start bit is confirmed at its middle,
// data and stop bits are sampled at their middles. A good stop bit yields a
// one-cycle o_byte_vld; a low stop bit yields a one-cycle o_frm_err instead.
module uart_byte_rx #(
    parameter int DIV = 4,
    parameter int OVS = 16
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx,
    output logic [7:0] o_byte,
    output logic       o_byte_vld,
    output logic       o_frm_err
);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int OW = (OVS > 1) ? $clog2(OVS) : 1;

    rx_state_t     r_state, w_next;
    logic [2:0]    r_sync;      // [1:0] synchroniser, [2] previous synced level
    logic [DW-1:0] r_div;
    logic [OW-1:0] r_ovs;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          w_rx, w_tick, w_mid_start, w_mid_bit;

    assign w_rx        = r_sync[1];
    assign w_tick      = (r_div == DW'(DIV - 1));
    assign w_mid_start = w_tick && (r_ovs == OW'(OVS / 2 - 1));
    assign w_mid_bit   = w_tick && (r_ovs == OW'(OVS - 1));

    // Next-state: a falling edge arms the start check; a high level at mid-start is a glitch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            RX_IDLE:  if (!w_rx && r_sync[2]) w_next = RX_START;
            RX_START: if (w_mid_start) w_next = w_rx ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_mid_bit && (r_bit == 3'd7)) w_next = RX_STOP;
            RX_STOP:  if (w_mid_bit) w_next = RX_IDLE;
            default:  w_next = RX_IDLE;
        endcase
    end

    // State, oversample timing, bit shifting and the byte/error strobes.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= RX_IDLE;
            r_sync     <= 3'b111;
            r_div      <= '0;
            r_ovs      <= '0;
            r_bit      <= '0;
            r_shift    <= '0;
            o_byte     <= '0;
            o_byte_vld <= 1'b0;
            o_frm_err  <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_sync     <= {r_sync[1:0], i_rx};
            o_byte_vld <= 1'b0;
            o_frm_err  <= 1'b0;
            if (r_state == RX_IDLE || (r_state == RX_START && w_mid_start)) begin
                r_div <= '0;
                r_ovs <= '0;
                r_bit <= '0;
            end else begin
                r_div <= w_tick ? '0 : r_div + DW'(1);
                if (w_mid_bit)   r_ovs <= '0;
                else if (w_tick) r_ovs <= r_ovs + OW'(1);
                if (r_state == RX_DATA && w_mid_bit) begin
                    r_shift <= {w_rx, r_shift[7:1]};
                    r_bit   <= r_bit + 3'd1;
                end
                if (r_state == RX_STOP && w_mid_bit) begin
                    o_byte     <= r_shift;
                    o_byte_vld <= w_rx;
                    o_frm_err  <= !w_rx;
                end
            end
        end
    end

endmodule

// File: rtl/uart_prog_loader.sv
// UART boot loader: parses SEG/CNT_LO/CNT_HI headers, packs data bytes
// little-endian into 32-bit words, pulses upg_wen_o per word and reports
// a one-byte status ('O' on completion, 'E' on a fault) on upg_tx_o.
module uart_prog_loader
    import upg_pkg::*;
#(
    parameter int CLK_HZ = 10_000_000,
    parameter int BAUD   = 128_000,
    parameter int OVS    = 16
) (
    input  logic        upg_clk_i,
    input  logic        upg_rst_i,
    input  logic        upg_rx_i,
    output logic        upg_clk_o,
    output logic        upg_wen_o,
    output logic [14:0] upg_adr_o,
    output logic [31:0] upg_dat_o,
    output logic        upg_done_o,
    output logic        upg_tx_o
);

    localparam int DIV     = CLK_HZ / (BAUD * OVS);
    localparam int BIT_CYC = DIV * OVS;
    localparam int CW      = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;

    ld_state_t     r_state, w_next;
    logic [7:0]    w_byte;
    logic          w_bvld, w_ferr, w_tx_req;
    logic [7:0]    w_tx_byte;
    logic [15:0]   w_n;
    logic          r_target, r_last, r_done, r_wen;
    logic [15:0]   r_cnt;
    logic [14:0]   r_words;
    logic [1:0]    r_bk;
    logic [31:0]   r_word, r_dat;
    logic [14:0]   r_adr;
    logic          r_pend, r_tx_busy;
    logic [7:0]    r_pend_byte;
    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cyc;
    logic [3:0]    r_tx_bits;

    uart_byte_rx #(.DIV(DIV), .OVS(OVS)) u_rx (
        .i_clk      (upg_clk_i),
        .i_rst_n    (upg_rst_i),
        .i_rx       (upg_rx_i),
        .o_byte     (w_byte),
        .o_byte_vld (w_bvld),
        .o_frm_err  (w_ferr)
    );

    assign upg_clk_o  = upg_clk_i;
    assign upg_wen_o  = r_wen;
    assign upg_adr_o  = r_adr;
    assign upg_dat_o  = r_dat;
    assign upg_done_o = r_done;
    assign upg_tx_o   = r_tx_busy ? r_tx_sh[0] : 1'b1;

    // Loader sequencing and status-byte requests.
    always_comb begin
        w_next    = r_state;
        w_tx_req  = 1'b0;
        w_tx_byte = ACK_OK;
        w_n       = {w_byte, r_cnt[7:0]};
        case (r_state)
            HDR_SEG: if (w_ferr) w_next = ERR;
                     else if (w_bvld) w_next = seg_ok(w_byte) ? HDR_LO : ERR;
            HDR_LO:  if (w_ferr) w_next = ERR;
                     else if (w_bvld) w_next = HDR_HI;
            HDR_HI:  if (w_ferr) w_next = ERR;
                     else if (w_bvld) begin
                         if (w_n == 16'd0)                 w_next = r_last ? DONE : HDR_SEG;
                         else if (w_n > 16'(MAX_WORDS))    w_next = ERR;
                         else                              w_next = DATA;
                     end
            DATA:    if (w_ferr) w_next = ERR;
                     else if (w_bvld && r_bk == 2'd3 && ({1'b0, r_words} + 16'd1 == r_cnt))
                         w_next = r_last ? DONE : HDR_SEG;
            DONE:    w_next = DONE;
            ERR: begin
                w_tx_req  = 1'b1;
                w_tx_byte = ACK_ERR;
                w_next    = HDR_SEG;
            end
            default: w_next = HDR_SEG;
        endcase
        if (w_next == DONE && r_state != DONE) w_tx_req = 1'b1;
    end

    // Header capture, word packing and the write strobe.
    always_ff @(posedge upg_clk_i or negedge upg_rst_i) begin
        if (!upg_rst_i) begin
            r_state  <= HDR_SEG;
            r_target <= 1'b0;
            r_last   <= 1'b0;
            r_cnt    <= '0;
            r_words  <= '0;
            r_bk     <= '0;
            r_word   <= '0;
            r_wen    <= 1'b0;
            r_adr    <= '0;
            r_dat    <= '0;
            r_done   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_wen   <= 1'b0;
            if (w_bvld) begin
                case (r_state)
                    HDR_SEG: begin
                        r_target <= w_byte[SEG_TARGET_BIT];
                        r_last   <= w_byte[SEG_LAST_BIT];
                        r_words  <= '0;
                        r_bk     <= '0;
                    end
                    HDR_LO:  r_cnt[7:0]  <= w_byte;
                    HDR_HI:  r_cnt[15:8] <= w_byte;
                    DATA: begin
                        r_word <= {w_byte, r_word[31:8]};
                        r_bk   <= r_bk + 2'd1;
                        if (r_bk == 2'd3) begin
                            r_wen   <= 1'b1;
                            r_adr   <= {r_target, r_words[13:0]};
                            r_dat   <= {w_byte, r_word[31:8]};
                            r_words <= r_words + 15'd1;
                        end
                    end
                    default: ;
                endcase
            end
            // A fault drops any partial word and restarts word numbering.
            if (w_next == ERR) begin
                r_words <= '0;
                r_bk    <= '0;
            end
            if (w_next == DONE) r_done <= 1'b1;
        end
    end

    // Status transmitter: one pending slot feeding a 10-bit 8N1 shifter.
    always_ff @(posedge upg_clk_i or negedge upg_rst_i) begin
        if (!upg_rst_i) begin
            r_pend      <= 1'b0;
            r_pend_byte <= '0;
            r_tx_busy   <= 1'b0;
            r_tx_sh     <= '1;
            r_tx_cyc    <= '0;
            r_tx_bits   <= '0;
        end else begin
            if (w_tx_req) begin
                r_pend      <= 1'b1;
                r_pend_byte <= w_tx_byte;
            end
            if (!r_tx_busy) begin
                if (r_pend) begin
                    r_tx_busy <= 1'b1;
                    r_tx_sh   <= {1'b1, r_pend_byte, 1'b0};
                    r_tx_cyc  <= '0;
                    r_tx_bits <= '0;
                    r_pend    <= w_tx_req;
                end
            end else if (r_tx_cyc == CW'(BIT_CYC - 1)) begin
                r_tx_cyc <= '0;
                r_tx_sh  <= {1'b1, r_tx_sh[9:1]};
                if (r_tx_bits == 4'd9) r_tx_busy <= 1'b0;
                else                   r_tx_bits <= r_tx_bits + 4'd1;
            end else begin
                r_tx_cyc <= r_tx_cyc + CW'(1);
            end
        end
    end

endmodule
